pipe_hazard_ctrl: RTL and testbench

// Hazard/sequencing controller for the IF/ID and ID/EX pipeline registers.

---
 rtl/pipe_hazard_ctrl_if.sv | 39 +++
 rtl/pipe_hazard_ctrl.sv | 168 ++++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/pipe_hazard_ctrl_if.sv
// Signal bundle between the decode/execute stages and the hazard controller.
// The master side is the pipeline: it supplies hazard sources and consumes the stage-register enables.
// The slave side is the controller itself.
interface pipe_hazard_ctrl_if #(
  parameter int CNT_W = 32
);
  logic [4:0]       id_rs;
  logic [4:0]       id_rt;
  logic             id_uses_rt;
  logic             ex_mem_read;
  logic [4:0]       ex_write_addr;
  logic             ex_redirect;
  logic             mc_start;
  logic             mc_done;
  logic             pc_write;
  logic             ifid_write;
  logic             ifid_flush;
  logic             idex_flush;
  logic             idex_hold;
  logic             pc_sel_redir;
  logic             mc_timeout;
  logic [1:0]       state;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output id_rs, id_rt, id_uses_rt, ex_mem_read, ex_write_addr,
           ex_redirect, mc_start, mc_done,
    input  pc_write, ifid_write, ifid_flush, idex_flush, idex_hold,
           pc_sel_redir, mc_timeout, state, stall_cnt, flush_cnt
  );

  modport slave (
    input  id_rs, id_rt, id_uses_rt, ex_mem_read, ex_write_addr,
           ex_redirect, mc_start, mc_done,
    output pc_write, ifid_write, ifid_flush, idex_flush, idex_hold,
           pc_sel_redir, mc_timeout, state, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/sequencing controller for the IF/ID and ID/EX pipeline registers.
// Handles load-use stalls, branch/jump redirect flushes and multi-cycle EX
// freezes with a watchdog. Outputs are combinational from state and inputs.
// Optional feature macro: PIPE_PERF_CNT_EN builds saturating stall/flush
// performance counters; without it stall_cnt/flush_cnt are constant zero.
module pipe_hazard_ctrl #(
  parameter int FLUSH_CYCLES = 2,
  parameter int MC_TIMEOUT   = 64,
  parameter int CNT_W        = 32
) (
  input  logic                 clock,
  input  logic                 reset,
  pipe_hazard_ctrl_if.slave    bus
);

  localparam int FW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES + 1) : 1;
  localparam int WW = $clog2(MC_TIMEOUT + 1);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    FLUSH   = 2'd1,
    MC_WAIT = 2'd2
  } state_t;

  state_t        state_q, state_nxt;
  logic [FW-1:0] fcnt_q, fcnt_nxt;
  logic [WW-1:0] wcnt_q, wcnt_nxt;

  logic pc_write, ifid_write, ifid_flush, idex_flush, idex_hold;
  logic pc_sel_redir, mc_timeout;
  logic redir_taken;
  logic load_use;

  // Load-use: the load in EX writes a register the ID instruction reads ($zero never hazards)
  always_comb begin
    load_use = bus.ex_mem_read && (bus.ex_write_addr != 5'd0) &&
               ((bus.ex_write_addr == bus.id_rs) ||
                (bus.id_uses_rt && (bus.ex_write_addr == bus.id_rt)));
  end

  // Next-state and stage-register controls; reset forces a flushed, frozen front end
  always_comb begin
    state_nxt    = state_q;
    fcnt_nxt     = fcnt_q;
    wcnt_nxt     = wcnt_q;
    pc_write     = 1'b1;
    ifid_write   = 1'b1;
    ifid_flush   = 1'b0;
    idex_flush   = 1'b0;
    idex_hold    = 1'b0;
    pc_sel_redir = 1'b0;
    mc_timeout   = 1'b0;
    redir_taken  = 1'b0;

    case (state_q)
      RUN: begin
        if (bus.ex_redirect) begin
          pc_sel_redir = 1'b1;
          ifid_flush   = 1'b1;
          idex_flush   = 1'b1;
          redir_taken  = 1'b1;
          if (FLUSH_CYCLES > 1) begin
            state_nxt = FLUSH;
            fcnt_nxt  = FW'(FLUSH_CYCLES - 1);
          end
        end else if (bus.mc_start) begin
          pc_write   = 1'b0;
          ifid_write = 1'b0;
          idex_hold  = 1'b1;
          state_nxt  = MC_WAIT;
          wcnt_nxt   = '0;
        end else if (load_use) begin
          pc_write   = 1'b0;
          ifid_write = 1'b0;
          idex_flush = 1'b1;
        end
      end

      FLUSH: begin
        // EX holds a bubble here, so a redirect request cannot be genuine
        ifid_flush = 1'b1;
        idex_flush = 1'b1;
        if (fcnt_q == FW'(1)) begin
          state_nxt = RUN;
        end else begin
          fcnt_nxt = fcnt_q - FW'(1);
        end
      end

      MC_WAIT: begin
        if (bus.mc_done) begin
          state_nxt = RUN;
        end else if (wcnt_q == WW'(MC_TIMEOUT - 1)) begin
          mc_timeout = 1'b1;
          state_nxt  = RUN;
        end else begin
          pc_write   = 1'b0;
          ifid_write = 1'b0;
          idex_hold  = 1'b1;
          wcnt_nxt   = wcnt_q + WW'(1);
        end
      end

      default: state_nxt = RUN;
    endcase

    // A bubble insert and a freeze of ID/EX are mutually exclusive; the bubble wins
    if (idex_flush) idex_hold = 1'b0;

    if (reset) begin
      pc_write     = 1'b0;
      ifid_write   = 1'b0;
      ifid_flush   = 1'b1;
      idex_flush   = 1'b1;
      idex_hold    = 1'b0;
      pc_sel_redir = 1'b0;
      mc_timeout   = 1'b0;
      redir_taken  = 1'b0;
      state_nxt    = RUN;
    end
  end

  // State and sequencing counters
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= RUN;
      fcnt_q  <= '0;
      wcnt_q  <= '0;
    end else begin
      state_q <= state_nxt;
      fcnt_q  <= fcnt_nxt;
      wcnt_q  <= wcnt_nxt;
    end
  end

  assign bus.pc_write     = pc_write;
  assign bus.ifid_write   = ifid_write;
  assign bus.ifid_flush   = ifid_flush;
  assign bus.idex_flush   = idex_flush;
  assign bus.idex_hold    = idex_hold;
  assign bus.pc_sel_redir = pc_sel_redir;
  assign bus.mc_timeout   = mc_timeout;
  assign bus.state        = state_q;

`ifdef PIPE_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

  // Saturating performance counters: frozen-PC cycles and accepted redirects
  always_ff @(posedge clock) begin
    if (reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (!pc_write && (stall_cnt_q != {CNT_W{1'b1}}))
        stall_cnt_q <= stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      if (redir_taken && (flush_cnt_q != {CNT_W{1'b1}}))
        flush_cnt_q <= flush_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign bus.stall_cnt = stall_cnt_q;
  assign bus.flush_cnt = flush_cnt_q;
`else
  assign bus.stall_cnt = {CNT_W{1'b0}};
  assign bus.flush_cnt = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl (FLUSH_CYCLES=2, MC_TIMEOUT=8).
// Each cycle the bench model predicts the outputs and queues them; the DUT
// outputs are popped and compared on the falling edge.
module tb_pipe_hazard_ctrl;

  localparam int FC    = 2;
  localparam int MT    = 8;
  localparam int CNT_W = 32;

  logic clock = 1'b0;
  logic reset;

  always #5 clock = ~clock;

  pipe_hazard_ctrl_if #(.CNT_W(CNT_W)) bus ();

  pipe_hazard_ctrl #(
    .FLUSH_CYCLES(FC),
    .MC_TIMEOUT  (MT),
    .CNT_W       (CNT_W)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus.slave)
  );

  typedef struct packed {
    logic        pc_write;
    logic        ifid_write;
    logic        ifid_flush;
    logic        idex_flush;
    logic        idex_hold;
    logic        pc_sel_redir;
    logic        mc_timeout;
    logic [1:0]  state;
    logic [31:0] stall;
    logic [31:0] flush;
  } exp_t;

  exp_t exp_q[$];

  int total = 0;
  int bad   = 0;
  int cyc_n = 0;

  // model state
  int          m_state;
  int          m_fcnt;
  int          m_wcnt;
  logic [31:0] m_stall;
  logic [31:0] m_flush;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s (cycle %0d): got %0h want %0h", tag, cyc_n, obs, exp);
    end
  endtask

  task automatic cyc(input logic rst, input logic [4:0] rs, input logic [4:0] rt,
                     input logic urt, input logic mrd, input logic [4:0] wa,
                     input logic redir, input logic ms, input logic md);
    exp_t e;
    exp_t got;
    int   n_state, n_fcnt, n_wcnt;
    logic lu;
    reset             = rst;
    bus.id_rs         = rs;
    bus.id_rt         = rt;
    bus.id_uses_rt    = urt;
    bus.ex_mem_read   = mrd;
    bus.ex_write_addr = wa;
    bus.ex_redirect   = redir;
    bus.mc_start      = ms;
    bus.mc_done       = md;

    // predict this cycle's outputs and the following state
    e = '0;
    e.pc_write   = 1'b1;
    e.ifid_write = 1'b1;
    e.state      = 2'(m_state);
    n_state = m_state;
    n_fcnt  = m_fcnt;
    n_wcnt  = m_wcnt;
    lu = mrd && (wa != 0) && ((wa == rs) || (urt && (wa == rt)));
    if (rst) begin
      e.pc_write   = 1'b0;
      e.ifid_write = 1'b0;
      e.ifid_flush = 1'b1;
      e.idex_flush = 1'b1;
      n_state = 0;
    end else if (m_state == 0) begin
      if (redir) begin
        e.pc_sel_redir = 1'b1;
        e.ifid_flush   = 1'b1;
        e.idex_flush   = 1'b1;
        if (FC > 1) begin
          n_state = 1;
          n_fcnt  = FC - 1;
        end
      end else if (ms) begin
        e.pc_write   = 1'b0;
        e.ifid_write = 1'b0;
        e.idex_hold  = 1'b1;
        n_state = 2;
        n_wcnt  = 0;
      end else if (lu) begin
        e.pc_write   = 1'b0;
        e.ifid_write = 1'b0;
        e.idex_flush = 1'b1;
      end
    end else if (m_state == 1) begin
      e.ifid_flush = 1'b1;
      e.idex_flush = 1'b1;
      if (m_fcnt == 1) n_state = 0;
      else n_fcnt = m_fcnt - 1;
    end else begin
      if (md) begin
        n_state = 0;
      end else if (m_wcnt == MT - 1) begin
        e.mc_timeout = 1'b1;
        n_state = 0;
      end else begin
        e.pc_write   = 1'b0;
        e.ifid_write = 1'b0;
        e.idex_hold  = 1'b1;
        n_wcnt = m_wcnt + 1;
      end
    end
`ifdef PIPE_PERF_CNT_EN
    e.stall = m_stall;
    e.flush = m_flush;
`else
    e.stall = 32'd0;
    e.flush = 32'd0;
`endif
    exp_q.push_back(e);

    @(negedge clock);
    got = exp_q.pop_front();
    chk("pc_write",     {31'd0, bus.pc_write},     {31'd0, got.pc_write});
    chk("ifid_write",   {31'd0, bus.ifid_write},   {31'd0, got.ifid_write});
    chk("ifid_flush",   {31'd0, bus.ifid_flush},   {31'd0, got.ifid_flush});
    chk("idex_flush",   {31'd0, bus.idex_flush},   {31'd0, got.idex_flush});
    chk("idex_hold",    {31'd0, bus.idex_hold},    {31'd0, got.idex_hold});
    chk("pc_sel_redir", {31'd0, bus.pc_sel_redir}, {31'd0, got.pc_sel_redir});
    chk("mc_timeout",   {31'd0, bus.mc_timeout},   {31'd0, got.mc_timeout});
    chk("state",        {30'd0, bus.state},        {30'd0, got.state});
    chk("stall_cnt",    bus.stall_cnt,             got.stall);
    chk("flush_cnt",    bus.flush_cnt,             got.flush);

    // commit model state for the rising edge
    if (rst) begin
      m_stall = '0;
      m_flush = '0;
    end else begin
      if (!e.pc_write && (m_stall != 32'hFFFF_FFFF)) m_stall = m_stall + 1;
      if (e.pc_sel_redir && (m_flush != 32'hFFFF_FFFF)) m_flush = m_flush + 1;
    end
    m_state = n_state;
    m_fcnt  = n_fcnt;
    m_wcnt  = n_wcnt;
    cyc_n++;
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 5'd1, 5'd2, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    reset             = 1'b1;
    bus.id_rs         = '0;
    bus.id_rt         = '0;
    bus.id_uses_rt    = 1'b0;
    bus.ex_mem_read   = 1'b0;
    bus.ex_write_addr = '0;
    bus.ex_redirect   = 1'b0;
    bus.mc_start      = 1'b0;
    bus.mc_done       = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    m_state = 0;
    m_fcnt  = 0;
    m_wcnt  = 0;
    m_stall = '0;
    m_flush = '0;

    // reset outputs, then plain RUN defaults
    cyc(1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    cyc(1, 5'd8, 5'd0, 1'b0, 1'b1, 5'd8, 1'b1, 1'b1, 1'b0);
    idle(2);

    // load-use on rs, then release; load-use on rt
    cyc(0, 5'd8, 5'd3, 1'b0, 1'b1, 5'd8, 1'b0, 1'b0, 1'b0);
    cyc(0, 5'd8, 5'd3, 1'b0, 1'b0, 5'd8, 1'b0, 1'b0, 1'b0);
    cyc(0, 5'd4, 5'd9, 1'b1, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0);
    idle(1);

    // no false stall on $zero or on an unused rt
    cyc(0, 5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
    cyc(0, 5'd3, 5'd9, 1'b0, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0);

    // redirect: one cycle of redirect, two cycles of flush; second redirect in FLUSH is ignored
    cyc(0, 5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0);
    idle(2);
    cyc(0, 5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0);
    cyc(0, 5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0);
    idle(2);

    // redirect beats simultaneous mc_start and load-use
    cyc(0, 5'd7, 5'd2, 1'b0, 1'b1, 5'd7, 1'b1, 1'b1, 1'b0);
    idle(2);

    // MC op finished on the 5th MC_WAIT cycle
    cyc(0, 5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) cyc(0, 5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    cyc(0, 5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
    idle(1);

    // mc_start together with load-use takes the MC path
    cyc(0, 5'd6, 5'd2, 1'b0, 1'b1, 5'd6, 1'b0, 1'b1, 1'b0);
    cyc(0, 5'd6, 5'd2, 1'b0, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0);
    cyc(0, 5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
    idle(1);

    // watchdog expiry with no mc_done
    cyc(0, 5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < MT; i++) cyc(0, 5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    idle(1);

    // mc_done on the timeout cycle suppresses mc_timeout
    cyc(0, 5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < MT - 1; i++) cyc(0, 5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    cyc(0, 5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
    idle(1);

    // reset while MC_WAIT with wcnt=3
    cyc(0, 5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) cyc(0, 5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    cyc(1, 5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    idle(2);

    // randomised traffic with small register numbers to provoke hazards
    for (int i = 0; i < 300; i++) begin
      cyc(($urandom_range(0, 49) == 0),
          5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
          5'($urandom_range(0, 3)),
          ($urandom_range(0, 7) == 0), ($urandom_range(0, 5) == 0),
          ($urandom_range(0, 4) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
